// File: rtl/carry_resolve_adder.sv
// ----------------------------------------------------------------------------
// carry_resolve_adder
//
// Purpose:
//    Resolves a pair of operands into a true (A + B + cin) result without
//    using a carry chain. The block repeatedly applies a half-adder pass to a
//    sum word S and a carry word C:
//       S' = S ^ C
//       C' = (S & C) << 1
//    until the carry word is zero. The sum word then holds the full result.
//    The first pass is formed directly from the operands when they are
//    accepted. Latency is data dependent and bounded by WORD_WIDTH+1 passes.
//
// Ports:
//    clock          in   1            sole clock, all state on rising edge
//    reset_n        in   1            synchronous, active-low reset
//    in_valid       in   1            operands present
//    in_ready       out  1            block can accept operands
//    in_A           in   WORD_WIDTH   addend A
//    in_B           in   WORD_WIDTH   addend B
//    in_carry_in    in   1            carry into bit 0
//    out_valid      out  1            result present
//    out_ready      in   1            consumer takes result
//    out_sum        out  WORD_WIDTH   (A+B+cin) mod 2^WORD_WIDTH
//    out_carry_out  out  1            bit WORD_WIDTH of A+B+cin
//    out_passes     out  COUNT_WIDTH  half-adder passes used
//    busy           out  1            high while iterating or holding a result
// ----------------------------------------------------------------------------
module carry_resolve_adder #(
   parameter int WORD_WIDTH  = 36,
   parameter int COUNT_WIDTH = 6
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORD_WIDTH-1:0]  in_A,
   input  logic [WORD_WIDTH-1:0]  in_B,
   input  logic                   in_carry_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORD_WIDTH-1:0]  out_sum,
   output logic                   out_carry_out,
   output logic [COUNT_WIDTH-1:0] out_passes,
   output logic                   busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ITERATE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_nextState;

   // Working registers of the half-adder iteration.
   logic [WORD_WIDTH-1:0]  r_sumWord;
   logic [WORD_WIDTH-1:0]  r_carryWord;
   logic                   r_carryOut;
   logic [COUNT_WIDTH-1:0] r_passes;

   // Result registers presented to the consumer; they hold through IDLE.
   logic [WORD_WIDTH-1:0]  r_outSum;
   logic                   r_outCarry;
   logic [COUNT_WIDTH-1:0] r_outPasses;

   logic                   w_accept;

   // First pass, formed straight from the operands.
   logic [WORD_WIDTH-1:0]  w_loadSum;
   logic [WORD_WIDTH-1:0]  w_loadCarry;
   logic                   w_loadCout;

   // Subsequent passes, formed from the working registers.
   logic [WORD_WIDTH-1:0]  w_overlap;
   logic [WORD_WIDTH-1:0]  w_iterSum;
   logic [WORD_WIDTH-1:0]  w_iterCarry;
   logic                   w_iterCout;
   logic [COUNT_WIDTH-1:0] w_iterPasses;

   // Whichever pass is being performed this cycle.
   logic                   w_passEnable;
   logic [WORD_WIDTH-1:0]  w_passSum;
   logic [WORD_WIDTH-1:0]  w_passCarry;
   logic                   w_passCout;
   logic [COUNT_WIDTH-1:0] w_passCount;
   logic                   w_passFinal;

   // Handshake and status. in_ready deliberately depends only on state and
   // reset so the upstream stage never sees a combinational path from its own
   // valid back into ready.
   assign in_ready  = (r_state == IDLE) & reset_n;
   assign w_accept  = in_valid & in_ready;
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == ITERATE) | (r_state == DONE);

   assign out_sum       = r_outSum;
   assign out_carry_out = r_outCarry;
   assign out_passes    = r_outPasses;

   // Pass 1: the operand pair itself is a half-adder input. The incoming
   // carry drops into bit 0 of the carry word, which is always free after
   // the left shift. A carry generated at the top bit leaves the word and is
   // recorded directly as carry-out.
   assign w_loadSum   = in_A ^ in_B;
   assign w_loadCarry = ((in_A & in_B) << 1) | {{(WORD_WIDTH-1){1'b0}}, in_carry_in};
   assign w_loadCout  = in_A[WORD_WIDTH-1] & in_B[WORD_WIDTH-1];

   // Later passes: the bit shifted out of the carry word goes to carry-out
   // only, never wrapping back to bit 0. At most one pass can ever produce
   // that bit, so OR-ing it in cannot double count.
   assign w_overlap    = r_sumWord & r_carryWord;
   assign w_iterSum    = r_sumWord ^ r_carryWord;
   assign w_iterCarry  = w_overlap << 1;
   assign w_iterCout   = r_carryOut | w_overlap[WORD_WIDTH-1];
   assign w_iterPasses = r_passes + COUNT_WIDTH'(1);

   // Select the pass for this cycle: the load pass on accept in IDLE, or an
   // iteration pass while in ITERATE. Nothing advances in DONE.
   always_comb begin
      w_passEnable = 1'b0;
      w_passSum    = w_iterSum;
      w_passCarry  = w_iterCarry;
      w_passCout   = w_iterCout;
      w_passCount  = w_iterPasses;
      if (r_state == IDLE) begin
         w_passEnable = w_accept;
         w_passSum    = w_loadSum;
         w_passCarry  = w_loadCarry;
         w_passCout   = w_loadCout;
         w_passCount  = COUNT_WIDTH'(1);
      end else if (r_state == ITERATE) begin
         w_passEnable = 1'b1;
      end
   end

   // A pass that leaves no carry behind completes the addition.
   assign w_passFinal = w_passEnable & (w_passCarry == '0);

   // State register; reset wins over everything, including a pass in flight.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. DONE holds for as long as the consumer stalls, which
   // also keeps in_ready low so no new operands can overlap a pending result.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = w_passFinal ? DONE : ITERATE;
            end
         end
         ITERATE: begin
            w_nextState = w_passFinal ? DONE : ITERATE;
         end
         DONE: begin
            if (out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Working registers advance on every pass. All four move together so the
   // pass count always matches the sum/carry pair it describes.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_sumWord   <= '0;
         r_carryWord <= '0;
         r_carryOut  <= 1'b0;
         r_passes    <= '0;
      end else if (w_passEnable) begin
         r_sumWord   <= w_passSum;
         r_carryWord <= w_passCarry;
         r_carryOut  <= w_passCout;
         r_passes    <= w_passCount;
      end
   end

   // Result registers capture on the final pass, on the same edge that moves
   // the FSM into DONE. They are untouched otherwise, so the last result stays
   // visible through IDLE and the next ITERATE.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_outSum    <= '0;
         r_outCarry  <= 1'b0;
         r_outPasses <= '0;
      end else if (w_passFinal) begin
         r_outSum    <= w_passSum;
         r_outCarry  <= w_passCout;
         r_outPasses <= w_passCount;
      end
   end

endmodule

// File: tb/tb_carry_resolve_adder.sv
// ----------------------------------------------------------------------------
// tb_carry_resolve_adder
//
// Purpose:
//    Self-checking bench for carry_resolve_adder at WORD_WIDTH=8. Directed
//    vectors with hand-computed results, a stalled consumer, reset during
//    iteration, back-to-back operations and a random sweep against
//    {cout,sum} == A + B + cin.
// ----------------------------------------------------------------------------
module tb_carry_resolve_adder;

   localparam int W    = 8;
   localparam int CW   = 4;
   localparam int MAXP = W + 1;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_A;
   logic [W-1:0]  in_B;
   logic          in_carry_in;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_carry_out;
   logic [CW-1:0] out_passes;
   logic          busy;

   int checkCount = 0;
   int errorCount = 0;

   carry_resolve_adder #(
      .WORD_WIDTH  (W),
      .COUNT_WIDTH (CW)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_A          (in_A),
      .in_B          (in_B),
      .in_carry_in   (in_carry_in),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_sum       (out_sum),
      .out_carry_out (out_carry_out),
      .out_passes    (out_passes),
      .busy          (busy)
   );

   // 10 ns clock.
   always #5 clock = ~clock;

   // Reaching the pass limit with carry still outstanding means the
   // iteration failed to converge.
   always @(negedge clock) begin
      if (reset_n === 1'b1 && dut.r_passes >= CW'(MAXP) && dut.r_carryWord != '0) begin
         errorCount++;
         $display("[TB] FAIL pass_limit: passes=%0d carry=%h required carry 0", dut.r_passes, dut.r_carryWord);
      end
   end

   // Watchdog so the run always ends even if the DUT locks up.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Present one operand set, wait for acceptance, then count edges from the
   // accept edge (counted as 1) until out_valid is seen. Inputs are scrambled
   // right after acceptance so any late sampling would corrupt the result.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, output int latency);
      int waitCycles;
      in_A        = a;
      in_B        = b;
      in_carry_in = cin;
      in_valid    = 1'b1;
      waitCycles  = 0;
      while (in_ready !== 1'b1 && waitCycles < 50) begin
         @(posedge clock); #1;
         waitCycles++;
      end
      checkCount++;
      if (in_ready !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clock); #1;
      in_valid    = 1'b0;
      in_A        = 8'($urandom);
      in_B        = 8'($urandom);
      in_carry_in = 1'($urandom);
      latency     = 1;
      while (out_valid !== 1'b1 && latency < 3 * MAXP) begin
         @(posedge clock); #1;
         latency++;
      end
      checkCount++;
      if (out_valid !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL result_timeout: out_valid=%b required 1", out_valid);
      end
   endtask

   // Take the pending result with a single-cycle out_ready pulse.
   task automatic handOff();
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
   endtask

   // Reset values and in_ready gating by reset_n.
   task automatic test_reset();
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      in_A        = '0;
      in_B        = '0;
      in_carry_in = 1'b0;
      out_ready   = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkCount++;
      if ({out_valid, out_sum, out_carry_out, out_passes, busy, in_ready} !== '0) begin
         errorCount++;
         $display("[TB] FAIL reset_state: valid=%b sum=%h cout=%b passes=%0d busy=%b in_ready=%b required all 0",
                  out_valid, out_sum, out_carry_out, out_passes, busy, in_ready);
      end
      reset_n = 1'b1;
      #1;
      checkCount++;
      if (in_ready !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL reset_release_ready: in_ready=%b required 1", in_ready);
      end
   endtask

   // One directed vector: result, carry-out, pass count, latency, and the
   // handshake around the hand-off.
   task automatic test_vector(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic [W-1:0] expSum, input logic expCout,
                              input int expPasses);
      int lat;
      applyStimulus(a, b, cin, lat);
      checkCount++;
      if (out_sum !== expSum || out_carry_out !== expCout) begin
         errorCount++;
         $display("[TB] FAIL %s_result: sum=%h cout=%b required sum=%h cout=%b",
                  name, out_sum, out_carry_out, expSum, expCout);
      end
      checkCount++;
      if (out_passes !== CW'(expPasses)) begin
         errorCount++;
         $display("[TB] FAIL %s_passes: passes=%0d required %0d", name, out_passes, expPasses);
      end
      checkCount++;
      if (lat != expPasses) begin
         errorCount++;
         $display("[TB] FAIL %s_latency: latency=%0d required %0d", name, lat, expPasses);
      end
      checkCount++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL %s_done_flags: in_ready=%b busy=%b required 0/1", name, in_ready, busy);
      end
      handOff();
      checkCount++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL %s_handoff: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
      end
   endtask

   // Consumer stalls for 5 cycles: outputs must hold, no new accept allowed.
   // 0x3C + 0x0F + 1 = 0x4C, resolved in 4 passes.
   task automatic test_backpressure();
      int lat;
      applyStimulus(8'h3C, 8'h0F, 1'b1, lat);
      checkCount++;
      if (lat != 4) begin
         errorCount++;
         $display("[TB] FAIL bp_latency: latency=%0d required 4", lat);
      end
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checkCount++;
         if (out_valid !== 1'b1 || out_sum !== 8'h4C || out_carry_out !== 1'b0 ||
             out_passes !== 4'd4 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL bp_hold: cyc=%0d valid=%b sum=%h cout=%b passes=%0d in_ready=%b busy=%b required 1/4c/0/4/0/1",
                     i, out_valid, out_sum, out_carry_out, out_passes, in_ready, busy);
         end
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      handOff();
      checkCount++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_sum !== 8'h4C) begin
         errorCount++;
         $display("[TB] FAIL bp_release: valid=%b in_ready=%b busy=%b sum=%h required 0/1/0/4c",
                  out_valid, in_ready, busy, out_sum);
      end
   endtask

   // Reset asserted while the worst-case vector is mid-iteration, then a
   // normal operation to show recovery (0x12 + 0x34 = 0x46 in 3 passes).
   task automatic test_reset_mid_iterate();
      int lat;
      in_A        = 8'hFF;
      in_B        = 8'h00;
      in_carry_in = 1'b1;
      in_valid    = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
      end
      checkCount++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         errorCount++;
         $display("[TB] FAIL mid_iterate: busy=%b out_valid=%b required 1/0", busy, out_valid);
      end
      reset_n = 1'b0;
      @(posedge clock); #1;
      checkCount++;
      if ({out_valid, out_sum, out_carry_out, out_passes, busy, in_ready} !== '0) begin
         errorCount++;
         $display("[TB] FAIL mid_reset_state: valid=%b sum=%h cout=%b passes=%0d busy=%b in_ready=%b required all 0",
                  out_valid, out_sum, out_carry_out, out_passes, busy, in_ready);
      end
      reset_n = 1'b1;
      #1;
      checkCount++;
      if (in_ready !== 1'b1) begin
         errorCount++;
         $display("[TB] FAIL mid_reset_ready: in_ready=%b required 1", in_ready);
      end
      applyStimulus(8'h12, 8'h34, 1'b0, lat);
      checkCount++;
      if (out_sum !== 8'h46 || out_carry_out !== 1'b0 || out_passes !== 4'd3 || lat != 3) begin
         errorCount++;
         $display("[TB] FAIL mid_recover: sum=%h cout=%b passes=%0d lat=%0d required 46/0/3/3",
                  out_sum, out_carry_out, out_passes, lat);
      end
      handOff();
   endtask

   // Operands held valid across the hand-off: the next accept must land on
   // the edge right after hand-off, giving the 2-cycle minimum spacing.
   // 0x01 + 0x02 = 0x03 (1 pass), then 0x80 + 0x80 = 0x100 (1 pass).
   task automatic test_back_to_back();
      int lat;
      applyStimulus(8'h01, 8'h02, 1'b0, lat);
      in_A     = 8'h80;
      in_B     = 8'h80;
      in_carry_in = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      checkCount++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 8'h03) begin
         errorCount++;
         $display("[TB] FAIL b2b_gap: in_ready=%b out_valid=%b sum=%h required 1/0/03", in_ready, out_valid, out_sum);
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      checkCount++;
      if (out_valid !== 1'b1 || out_sum !== 8'h00 || out_carry_out !== 1'b1 || out_passes !== 4'd1) begin
         errorCount++;
         $display("[TB] FAIL b2b_second: valid=%b sum=%h cout=%b passes=%0d required 1/00/1/1",
                  out_valid, out_sum, out_carry_out, out_passes);
      end
      handOff();
   endtask

   // Random operands with random consumer stalls.
   task automatic test_random(input int count);
      int          lat;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic        cin;
      logic [W:0]  expected;
      for (int n = 0; n < count; n++) begin
         a   = 8'($urandom);
         b   = 8'($urandom);
         cin = 1'($urandom);
         expected = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         applyStimulus(a, b, cin, lat);
         checkCount++;
         if ({out_carry_out, out_sum} !== expected) begin
            errorCount++;
            $display("[TB] FAIL rand_sum: a=%h b=%h cin=%b got %h required %h",
                     a, b, cin, {out_carry_out, out_sum}, expected);
         end
         checkCount++;
         if (out_passes < 4'd1 || out_passes > CW'(MAXP) || int'(out_passes) != lat) begin
            errorCount++;
            $display("[TB] FAIL rand_passes: a=%h b=%h cin=%b passes=%0d lat=%0d required equal and within 1..%0d",
                     a, b, cin, out_passes, lat, MAXP);
         end
         repeat ($urandom_range(0, 3)) begin
            @(posedge clock); #1;
         end
         handOff();
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_vector("zero",      8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1);
      test_vector("disjoint",  8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1);
      test_vector("ff_plus1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8);
      test_vector("ff_cin",    8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 9);
      test_vector("msb_out",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1);
      test_vector("alt_bits",  8'h55, 8'h55, 1'b0, 8'hAA, 1'b0, 2);
      test_vector("cin_only",  8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 2);
      test_vector("to_msb",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 8);
      test_backpressure();
      test_reset_mid_iterate();
      test_back_to_back();
      test_random(3000);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
